// File: rtl/uart_tx_scheduler_pkg.sv
// rtl/uart_tx_scheduler_pkg.sv - shared types, constants and helpers for the UART TX scheduler
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } tx_state_e;

    localparam logic UART_IDLE_LVL = 1'b1;
    localparam int   DEF_DATA_W    = 8;
    localparam int   FRAME_TICKS   = DEF_DATA_W + 3;

    // Start bit, data bits, stop bit, then one closing tick that ends the frame.
    function automatic int frame_ticks(input int data_w);
        return data_w + 3;
    endfunction

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// rtl/uart_tx_scheduler_if.sv - requester, tick generator and serial-line bundle
interface uart_tx_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    import uart_pkg::*;

    localparam int GID_W = clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      bps_start;
    logic                      clk_bps;
    logic                      uart_tx;
    logic                      busy;
    logic [GID_W-1:0]          grant_id;
    logic                      frame_done;
    logic                      timeout_err;

    modport master (
        output req_valid, req_data, clk_bps,
        input  req_ready, bps_start, uart_tx, busy, grant_id, frame_done, timeout_err
    );

    modport slave (
        input  req_valid, req_data, clk_bps,
        output req_ready, bps_start, uart_tx, busy, grant_id, frame_done, timeout_err
    );

endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// rtl/uart_tx_scheduler_rr_arbiter.sv - combinational round-robin pick of the first request after ptr
module rr_arbiter
    import uart_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic               any_o
);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest slot inward so the nearest valid index after ptr wins.
    always_comb begin
        cand      = '0;
        gnt_idx_o = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            cand = IDX_W'((int'(ptr_i) + off) % NUM_REQ);
            if (req_i[cand]) begin
                gnt_idx_o = cand;
            end
        end
        any_o            = |req_i;
        gnt_o            = '0;
        gnt_o[gnt_idx_o] = any_o;
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - shares one UART TX line and baud tick generator among NUM_REQ requesters
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 8,
    parameter int TICK_TIMEOUT = 4096
) (
    input  logic         clk,
    input  logic         rst_n,
    uart_tx_scheduler_if.slave sched_if
);

    localparam int IDX_W = clog2(NUM_REQ);
    localparam int WD_W  = clog2(TICK_TIMEOUT + 1);

    localparam logic [3:0]      TICK_START     = 4'd1;
    localparam logic [3:0]      TICK_LAST_DATA = 4'(DATA_W + 1);
    localparam logic [3:0]      TICK_STOP      = 4'(DATA_W + 2);
    localparam logic [WD_W-1:0] WD_LIMIT       = WD_W'(TICK_TIMEOUT);

    tx_state_e          state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   gid_q, gid_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic [3:0]         tick_q, tick_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic               tx_q, tx_d;
    logic               bps_q, bps_d;
    logic               busy_q, busy_d;
    logic [NUM_REQ-1:0] ready_q, ready_d;
    logic               done_q, done_d;
    logic               terr_q, terr_d;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;
    logic [DATA_W-1:0]  grant_byte;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req_i     (sched_if.req_valid),
        .ptr_i     (ptr_q),
        .gnt_o     (arb_gnt),
        .gnt_idx_o (arb_idx),
        .any_o     (arb_any)
    );

    always_comb begin
        grant_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
                grant_byte = sched_if.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        shift_d = shift_q;
        tick_d  = tick_q;
        wd_d    = wd_q;
        tx_d    = tx_q;
        bps_d   = bps_q;
        busy_d  = busy_q;
        ready_d = '0;
        done_d  = 1'b0;
        terr_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    ready_d = arb_gnt;
                    shift_d = grant_byte;
                    gid_d   = arb_idx;
                    ptr_d   = arb_idx;
                    busy_d  = 1'b1;
                    bps_d   = 1'b1;
                    tick_d  = '0;
                    wd_d    = '0;
                    tx_d    = UART_IDLE_LVL;
                    state_d = SEND;
                end
            end

            SEND: begin
                if (sched_if.clk_bps) begin
                    wd_d   = '0;
                    tick_d = tick_q + 4'd1;
                    if (tick_d == TICK_START) begin
                        tx_d = 1'b0;
                    end else if (tick_d <= TICK_LAST_DATA) begin
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                    end else if (tick_d == TICK_STOP) begin
                        tx_d = UART_IDLE_LVL;
                    end else begin
                        bps_d   = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = GAP;
                    end
                end else begin
                    wd_d = wd_q + WD_W'(1);
                    // Generator stalled: release the line and drop the byte.
                    if (wd_d == WD_LIMIT) begin
                        tx_d    = UART_IDLE_LVL;
                        bps_d   = 1'b0;
                        busy_d  = 1'b0;
                        terr_d  = 1'b1;
                        state_d = GAP;
                    end
                end
            end

            // One cycle with bps_start low lets the tick generator clear its counter.
            GAP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= IDX_W'(NUM_REQ - 1);
            gid_q   <= '0;
            shift_q <= '0;
            tick_q  <= '0;
            wd_q    <= '0;
            tx_q    <= UART_IDLE_LVL;
            bps_q   <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= '0;
            done_q  <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            shift_q <= shift_d;
            tick_q  <= tick_d;
            wd_q    <= wd_d;
            tx_q    <= tx_d;
            bps_q   <= bps_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            terr_q  <= terr_d;
        end
    end

    assign sched_if.req_ready   = ready_q;
    assign sched_if.bps_start   = bps_q;
    assign sched_if.uart_tx     = tx_q;
    assign sched_if.busy        = busy_q;
    assign sched_if.grant_id    = gid_q;
    assign sched_if.frame_done  = done_q;
    assign sched_if.timeout_err = terr_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - directed bench for uart_tx_scheduler with a modelled baud tick generator
module tb_uart_tx_scheduler;
    import uart_pkg::*;

    localparam int NUM_REQ      = 4;
    localparam int DATA_W       = 8;
    localparam int TICK_TIMEOUT = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic gen_tick = 1'b0;
    logic man_tick = 1'b0;
    int   tick_limit = 1000;
    int   vectors = 0;
    int   miscompares = 0;

    uart_tx_scheduler_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

    uart_tx_scheduler #(
        .NUM_REQ      (NUM_REQ),
        .DATA_W       (DATA_W),
        .TICK_TIMEOUT (TICK_TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sched_if (bus)
    );

    assign bus.clk_bps = gen_tick | man_tick;

    initial forever #20 clk = ~clk;

    // Baud generator model: first tick 8 clk after bps_start rises, then every 16 clk.
    initial begin : tick_gen
        int cnt;
        int sent;
        cnt  = 0;
        sent = 0;
        forever begin
            @(negedge clk);
            if (bus.bps_start !== 1'b1) begin
                cnt      = 0;
                sent     = 0;
                gen_tick = 1'b0;
            end else begin
                cnt++;
                if ((cnt % 16) == 8 && sent < tick_limit) begin
                    gen_tick = 1'b1;
                    sent++;
                end else begin
                    gen_tick = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            if (bus.clk_bps === 1'b1) seen = 1'b1;
        end
        chk("tick_seen", 32'(seen), 32'd1);
    endtask

    task automatic wait_grant(input int g);
        int n;
        n = 0;
        while (bus.req_ready === '0 && n < 100) begin
            step();
            n++;
        end
        chk("grant_latency", n, 1);
        chk("req_ready", bus.req_ready, 32'(4'b0001 << g));
        chk("grant_id", bus.grant_id, g);
        chk("busy_on_grant", bus.busy, 1);
        chk("bps_on_grant", bus.bps_start, 1);
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int k);
        if (k == 1) return 1'b0;
        if (k <= 9) return b[k-2];
        return 1'b1;
    endfunction

    task automatic send_frame(input logic [7:0] b);
        for (int k = 1; k <= 10; k++) begin
            wait_tick();
            chk($sformatf("tx_bit_%0d_of_%02h", k, b), bus.uart_tx, exp_bit(b, k));
        end
        wait_tick();
        chk("frame_done", bus.frame_done, 1);
        chk("bps_end", bus.bps_start, 0);
        chk("busy_end", bus.busy, 0);
        step();
        chk("frame_done_pulse", bus.frame_done, 0);
        chk("bps_gap", bus.bps_start, 0);
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        repeat (3) step();
        chk("rst_tx", bus.uart_tx, 1);
        chk("rst_bps", bus.bps_start, 0);
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_gid", bus.grant_id, 0);
        chk("rst_done", bus.frame_done, 0);
        chk("rst_terr", bus.timeout_err, 0);
        rst_n = 1'b1;
        step();

        // T6: ticks while idle are ignored
        for (int i = 0; i < 3; i++) begin
            man_tick = 1'b1;
            step();
            man_tick = 1'b0;
            step();
            chk("idle_tick_tx", bus.uart_tx, 1);
            chk("idle_tick_busy", bus.busy, 0);
            chk("idle_tick_bps", bus.bps_start, 0);
        end

        // T1: single byte 0x55 from requester 0
        bus.req_data[7:0] = 8'h55;
        bus.req_valid     = 4'b0001;
        wait_grant(0);
        bus.req_valid = '0;
        step();
        chk("ready_single_pulse", bus.req_ready, 0);
        send_frame(8'h55);

        // T2: fresh reset, all four request; order 0,1,2,3 with a gap between frames
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        bus.req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        bus.req_valid = 4'b1111;
        for (int g = 0; g < 4; g++) begin
            wait_grant(g);
            bus.req_valid[g] = 1'b0;
            step();
            chk("ready_one_per_byte", bus.req_ready, 0);
            send_frame(8'hA0 + 8'(g));
        end

        // T3: req1 served, then req1+req3 together -> 3 first
        bus.req_data[15:8] = 8'h3C;
        bus.req_valid      = 4'b0010;
        wait_grant(1);
        bus.req_valid = '0;
        send_frame(8'h3C);
        bus.req_data[15:8]  = 8'h5A;
        bus.req_data[31:24] = 8'hC3;
        bus.req_valid       = 4'b1010;
        wait_grant(3);
        bus.req_valid[3] = 1'b0;
        send_frame(8'hC3);
        wait_grant(1);
        bus.req_valid[1] = 1'b0;
        send_frame(8'h5A);

        // T4: ticks stop after tick 4, watchdog fires 64 cycles later
        tick_limit        = 4;
        bus.req_data[7:0] = 8'h00;
        bus.req_valid     = 4'b0001;
        wait_grant(0);
        bus.req_valid = '0;
        for (int k = 0; k < 4; k++) wait_tick();
        chk("t4_tx_before_abort", bus.uart_tx, 0);
        for (int n = 1; n <= 64; n++) begin
            step();
            if (n == 63) begin
                chk("t4_terr_early", bus.timeout_err, 0);
                chk("t4_busy_early", bus.busy, 1);
            end
            if (n == 64) begin
                chk("t4_terr", bus.timeout_err, 1);
                chk("t4_tx", bus.uart_tx, 1);
                chk("t4_busy", bus.busy, 0);
                chk("t4_bps", bus.bps_start, 0);
                chk("t4_no_done", bus.frame_done, 0);
            end
        end
        step();
        chk("t4_terr_pulse", bus.timeout_err, 0);
        step();
        tick_limit = 1000;

        // T5: reset during data bit 3; pointer returns to favour requester 0
        bus.req_data[7:0] = 8'hF7;
        bus.req_valid     = 4'b0001;
        wait_grant(0);
        bus.req_valid = '0;
        for (int k = 0; k < 5; k++) wait_tick();
        chk("t5_bit3", bus.uart_tx, 0);
        step();
        step();
        #10;
        rst_n = 1'b0;
        #1;
        chk("t5_async_tx", bus.uart_tx, 1);
        chk("t5_async_bps", bus.bps_start, 0);
        chk("t5_async_ready", bus.req_ready, 0);
        chk("t5_async_busy", bus.busy, 0);
        step();
        rst_n = 1'b1;
        bus.req_data  = {8'h00, 8'h00, 8'h22, 8'h11};
        bus.req_valid = 4'b0011;
        wait_grant(0);
        bus.req_valid = '0;
        send_frame(8'h11);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
